// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle control FSM and the shared
// datapath + memory port. master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alu_zero;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        alu_fn7_en;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        halt;
  logic [3:0]  state;
  logic [31:0] instret;

  modport master (
    input  opcode, funct3, alu_zero, mem_ack,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_a,
           alu_src_b, alu_op, alu_fn7_en, reg_we, wb_sel, halt, state, instret
  );

  modport slave (
    output opcode, funct3, alu_zero, mem_ack,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_a,
           alu_src_b, alu_op, alu_fn7_en, reg_we, wb_sel, halt, state, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle femtoRV32 core: sequences fetch, decode,
// execute, memory and write-back, counts retired instructions, halts on bad encodings.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC_R = 4'd3,
    EXEC_I = 4'd4,
    ADDR   = 4'd5,
    MEM_RD = 4'd6,
    MEM_WR = 4'd7,
    WB_ALU = 4'd8,
    WB_MEM = 4'd9,
    BRANCH = 4'd10,
    JAL    = 4'd11,
    HALT   = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       alu_fn7_en;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       halt;
  } ctl_t;

  state_t      cur_state;
  state_t      next_state;
  ctl_t        ctl_q;
  logic [31:0] instret_q;
  logic        retire;

  function automatic state_t dispatch(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: dispatch = EXEC_R;
      7'b0010011: dispatch = EXEC_I;
      7'b0000011,
      7'b0100011: dispatch = ADDR;
      7'b1100011: dispatch = (f3 == 3'b000 || f3 == 3'b001) ? BRANCH : HALT;
      7'b1101111: dispatch = JAL;
      default:    dispatch = HALT;
    endcase
  endfunction

  // Moore part of the control word for a given state; registered alongside the state.
  function automatic ctl_t decode_ctl(input state_t s);
    decode_ctl = '0;
    case (s)
      FETCH: begin
        decode_ctl.mem_req   = 1'b1;
        decode_ctl.alu_src_b = 2'b01;
      end
      DECODE: decode_ctl.alu_src_b = 2'b10;
      EXEC_R: begin
        decode_ctl.alu_src_a  = 1'b1;
        decode_ctl.alu_op     = 2'b10;
        decode_ctl.alu_fn7_en = 1'b1;
      end
      EXEC_I: begin
        decode_ctl.alu_src_a = 1'b1;
        decode_ctl.alu_src_b = 2'b10;
        decode_ctl.alu_op    = 2'b10;
      end
      ADDR: begin
        decode_ctl.alu_src_a = 1'b1;
        decode_ctl.alu_src_b = 2'b10;
      end
      MEM_RD: begin
        decode_ctl.mem_req  = 1'b1;
        decode_ctl.addr_sel = 1'b1;
      end
      MEM_WR: begin
        decode_ctl.mem_req  = 1'b1;
        decode_ctl.mem_we   = 1'b1;
        decode_ctl.addr_sel = 1'b1;
      end
      WB_ALU: decode_ctl.reg_we = 1'b1;
      WB_MEM: begin
        decode_ctl.reg_we = 1'b1;
        decode_ctl.wb_sel = 2'b01;
      end
      BRANCH: begin
        decode_ctl.alu_src_a = 1'b1;
        decode_ctl.alu_op    = 2'b01;
        decode_ctl.pc_src    = 1'b1;
      end
      JAL: begin
        decode_ctl.reg_we = 1'b1;
        decode_ctl.wb_sel = 2'b10;
        decode_ctl.pc_src = 1'b1;
      end
      HALT:    decode_ctl.halt = 1'b1;
      default: decode_ctl = '0;
    endcase
  endfunction

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:           next_state = FETCH;
      FETCH:          if (bus.mem_ack) next_state = DECODE;
      DECODE:         next_state = dispatch(bus.opcode, bus.funct3);
      EXEC_R, EXEC_I: next_state = WB_ALU;
      ADDR:           next_state = (bus.opcode == 7'b0000011) ? MEM_RD : MEM_WR;
      MEM_RD:         if (bus.mem_ack) next_state = WB_MEM;
      MEM_WR:         if (bus.mem_ack) next_state = FETCH;
      WB_ALU, WB_MEM,
      BRANCH, JAL:    next_state = FETCH;
      HALT:           next_state = HALT;
      default:        next_state = HALT;
    endcase
  end

  // Only the final state of an instruction returning to FETCH counts as a retirement.
  assign retire = (next_state == FETCH) &&
                  (cur_state inside {WB_ALU, WB_MEM, MEM_WR, BRANCH, JAL});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      ctl_q     <= '0;
      instret_q <= '0;
    end else begin
      cur_state <= next_state;
      ctl_q     <= decode_ctl(next_state);
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  // Write enables must react to the ack in the same cycle to support zero-wait memory.
  always_comb begin
    bus.ir_we = 1'b0;
    bus.pc_we = 1'b0;
    case (cur_state)
      FETCH: begin
        bus.ir_we = bus.mem_ack;
        bus.pc_we = bus.mem_ack;
      end
      BRANCH:  bus.pc_we = (bus.funct3 == 3'b000) ? bus.alu_zero : ~bus.alu_zero;
      JAL:     bus.pc_we = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_req    = ctl_q.mem_req;
  assign bus.mem_we     = ctl_q.mem_we;
  assign bus.addr_sel   = ctl_q.addr_sel;
  assign bus.pc_src     = ctl_q.pc_src;
  assign bus.alu_src_a  = ctl_q.alu_src_a;
  assign bus.alu_src_b  = ctl_q.alu_src_b;
  assign bus.alu_op     = ctl_q.alu_op;
  assign bus.alu_fn7_en = ctl_q.alu_fn7_en;
  assign bus.reg_we     = ctl_q.reg_we;
  assign bus.wb_sel     = ctl_q.wb_sel;
  assign bus.halt       = ctl_q.halt;
  assign bus.state      = cur_state;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction is expanded by a reference
// model into per-cycle expected control words; a monitor compares them at negedge.
module tb_multicycle_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4,
                 S_ADDR = 5, S_MEM_RD = 6, S_MEM_WR = 7, S_WB_ALU = 8, S_WB_MEM = 9,
                 S_BRANCH = 10, S_JAL = 11, S_HALT = 12;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_SYS = 7'b1110011;

  typedef struct packed {
    logic [3:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        alu_fn7_en;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        halt;
    logic [31:0] instret;
  } snap_t;

  typedef struct {
    snap_t exp;
    logic  ack;
  } step_t;

  step_t       plan[$];
  snap_t       expq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_instret = '0;

  // Expected control word for one cycle of a given phase of an instruction.
  function automatic snap_t expect_for(input int st, input logic ack, input logic zero,
                                       input logic [2:0] f3);
    snap_t s;
    s = '0;
    s.state   = 4'(st);
    s.instret = model_instret;
    case (st)
      S_FETCH:  begin s.mem_req = 1; s.alu_src_b = 2'b01; s.ir_we = ack; s.pc_we = ack; end
      S_DECODE: s.alu_src_b = 2'b10;
      S_EXEC_R: begin s.alu_src_a = 1; s.alu_op = 2'b10; s.alu_fn7_en = 1; end
      S_EXEC_I: begin s.alu_src_a = 1; s.alu_src_b = 2'b10; s.alu_op = 2'b10; end
      S_ADDR:   begin s.alu_src_a = 1; s.alu_src_b = 2'b10; end
      S_MEM_RD: begin s.mem_req = 1; s.addr_sel = 1; end
      S_MEM_WR: begin s.mem_req = 1; s.mem_we = 1; s.addr_sel = 1; end
      S_WB_ALU: s.reg_we = 1;
      S_WB_MEM: begin s.reg_we = 1; s.wb_sel = 2'b01; end
      S_BRANCH: begin
        s.alu_src_a = 1; s.alu_op = 2'b01; s.pc_src = 1;
        s.pc_we = (f3 == 3'b000) ? zero : ~zero;
      end
      S_JAL:    begin s.reg_we = 1; s.wb_sel = 2'b10; s.pc_we = 1; s.pc_src = 1; end
      S_HALT:   s.halt = 1;
      default:  ;
    endcase
    return s;
  endfunction

  function automatic void add(input int st, input logic ack, input logic zero,
                              input logic [2:0] f3);
    step_t t;
    t.exp = expect_for(st, ack, zero, f3);
    t.ack = ack;
    plan.push_back(t);
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expands one instruction into its cycle list; returns 1 when it ends in HALT.
  function automatic bit build(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                               input int fetch_wait, input int mem_wait);
    bit halts;
    halts = 1'b0;
    plan.delete();
    for (int w = 0; w <= fetch_wait; w++) add(S_FETCH, (w == fetch_wait), zero, f3);
    add(S_DECODE, rbit(), zero, f3);
    if (op == OP_R) begin
      add(S_EXEC_R, rbit(), zero, f3);
      add(S_WB_ALU, rbit(), zero, f3);
    end else if (op == OP_I) begin
      add(S_EXEC_I, rbit(), zero, f3);
      add(S_WB_ALU, rbit(), zero, f3);
    end else if (op == OP_LD || op == OP_ST) begin
      add(S_ADDR, rbit(), zero, f3);
      for (int w = 0; w <= mem_wait; w++)
        add((op == OP_LD) ? S_MEM_RD : S_MEM_WR, (w == mem_wait), zero, f3);
      if (op == OP_LD) add(S_WB_MEM, rbit(), zero, f3);
    end else if (op == OP_BR && f3 <= 3'b001) begin
      add(S_BRANCH, rbit(), zero, f3);
    end else if (op == OP_JAL) begin
      add(S_JAL, rbit(), zero, f3);
    end else begin
      for (int i = 0; i < 100; i++) add(S_HALT, rbit(), zero, f3);
      halts = 1'b1;
    end
    return halts;
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                               input int limit);
    int n;
    n = (limit < 0 || limit > plan.size()) ? plan.size() : limit;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.opcode   = op;
      bus.funct3   = f3;
      bus.alu_zero = zero;
      bus.mem_ack  = plan[i].ack;
      expq.push_back(plan[i].exp);
    end
  endtask

  task automatic doReset();
    snap_t idle;
    idle = '0;
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.mem_ack   = rbit();
    model_instret = '0;
    expq.push_back(idle);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq.push_back(idle);
  endtask

  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                          input int fetch_wait, input int mem_wait);
    bit halts;
    halts = build(op, f3, zero, fetch_wait, mem_wait);
    applyStimulus(op, f3, zero, -1);
    if (halts) doReset();
    else model_instret = model_instret + 32'd1;
  endtask

  task automatic checkOutput(input snap_t e);
    snap_t a;
    a.state      = bus.state;
    a.mem_req    = bus.mem_req;
    a.mem_we     = bus.mem_we;
    a.addr_sel   = bus.addr_sel;
    a.ir_we      = bus.ir_we;
    a.pc_we      = bus.pc_we;
    a.pc_src     = bus.pc_src;
    a.alu_src_a  = bus.alu_src_a;
    a.alu_src_b  = bus.alu_src_b;
    a.alu_op     = bus.alu_op;
    a.alu_fn7_en = bus.alu_fn7_en;
    a.reg_we     = bus.reg_we;
    a.wb_sel     = bus.wb_sel;
    a.halt       = bus.halt;
    a.instret    = bus.instret;
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL ctl_word exp_state=%0d t=%0t actual=%h expected=%h",
               e.state, $time, a, e);
    end
  endtask

  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         r;
    bit         halts;
    bus.opcode   = '0;
    bus.funct3   = '0;
    bus.alu_zero = 1'b0;
    bus.mem_ack  = 1'b0;

    doReset();
    runInstr(OP_R, 3'b000, 1'b0, 0, 0);
    runInstr(OP_LD, 3'b010, 1'b0, 0, 3);
    runInstr(OP_BR, 3'b000, 1'b1, 0, 0);
    runInstr(OP_BR, 3'b001, 1'b1, 0, 0);
    runInstr(OP_I, 3'b000, 1'b0, 1, 0);
    runInstr(OP_JAL, 3'b000, 1'b0, 0, 0);
    runInstr(OP_ST, 3'b010, 1'b0, 2, 1);

    // Counter wrap: the retirement pending at the next edge takes 0xFFFFFFFF to 0.
    runInstr(OP_R, 3'b000, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    model_instret = 32'hFFFF_FFFF;
    model_instret = model_instret + 32'd1;
    runInstr(OP_I, 3'b000, 1'b0, 0, 0);

    runInstr(OP_SYS, 3'b000, 1'b0, 0, 0);
    runInstr(OP_R, 3'b000, 1'b0, 0, 0);
    runInstr(OP_BR, 3'b010, 1'b1, 0, 0);
    runInstr(OP_R, 3'b000, 1'b0, 0, 0);

    // Reset in the middle of a store's memory wait.
    halts = build(OP_ST, 3'b010, 1'b0, 0, 5);
    applyStimulus(OP_ST, 3'b010, 1'b0, 6);
    doReset();

    for (int i = 0; i < 50; i++) begin
      r  = $urandom_range(0, 19);
      f3 = 3'($urandom_range(0, 7));
      if (r < 4)       op = OP_R;
      else if (r < 8)  op = OP_I;
      else if (r < 11) op = OP_LD;
      else if (r < 14) op = OP_ST;
      else if (r < 17) begin op = OP_BR; f3 = 3'($urandom_range(0, 1)); end
      else if (r < 19) op = OP_JAL;
      else             op = 7'($urandom_range(0, 127));
      runInstr(op, f3, rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle femtoRV32 core. It sequences the shared datapath through fetch, decode, execute, memory and write-back. It drives the ALU-op code consumed by the ALU control unit and the mux/write-enable selects for PC, IR, register file and the single shared memory port. It also counts retired instructions and halts on unsupported encodings.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- alu_zero  in  1  ALU zero flag
- mem_ack  in  1  memory completion, single-cycle pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write qualifier for mem_req
- addr_sel  out  1  0 = PC, 1 = ALUOut
- ir_we  out  1  load IR and old_pc (PC before increment); MDR loads on every mem_ack
- pc_we  out  1  PC write enable
- pc_src  out  1  0 = live ALU result, 1 = ALUOut register
- alu_src_a  out  1  0 = old_pc/PC (PC in FETCH, old_pc otherwise), 1 = rs1
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- alu_fn7_en  out  1  gates IR[30] into the ALU control; 0 forces it to 0
- reg_we  out  1  register-file write
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC
- halt  out  1  core stopped
- state  out  4  current state, debug
- instret  out  32  retired-instruction count

## Operation
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, BRANCH 10, JAL 11, HALT 12. Values 13–15 go to HALT.
- Moore outputs decode from state only, except pc_we/ir_we, which also depend on mem_ack or alu_zero as listed. Any output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH: mem_req=1, addr_sel=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - On mem_ack: ir_we=1, pc_we=1, pc_src=0 (PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut = old_pc + imm. Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → ADDR
  - 1100011 with funct3 ∈ {000, 001} → BRANCH
  - 1101111 → JAL
  - anything else, including 1110011 → HALT
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, alu_fn7_en=1. Next: WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10. Next: WB_ALU.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, addr_sel=1. Goes to WB_MEM on mem_ack.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1. Goes to FETCH on mem_ack.
- WB_ALU: reg_we=1, wb_sel=00. Next: FETCH.
- WB_MEM: reg_we=1, wb_sel=01. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1. Next: FETCH.
  - pc_we = alu_zero for funct3=000 (BEQ), ~alu_zero for funct3=001 (BNE).
- JAL: reg_we=1, wb_sel=10, pc_we=1, pc_src=1. Next: FETCH.
- HALT: halt=1, all other outputs 0. Absorbing until reset.
- instret: increments by 1 on every transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH or JAL. It wraps from 0xFFFFFFFF to 0. A branch counts as retired whether or not it is taken.

## Timing
- Reset values: state=IDLE, instret=0, every control output 0 (mem_req=0, halt=0). Reset takes effect immediately and asynchronously.
- Reset mid-transaction: mem_req drops asynchronously and the pending mem_ack is discarded. The memory side must abort.
- mem_ack may arrive in the same cycle mem_req rises (zero-wait). With a zero-wait memory:
  - FETCH takes 1 cycle.
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and JAL: 3 cycles each.
- Each wait cycle on mem_ack adds 1 cycle.
- mem_ack is ignored outside FETCH, MEM_RD and MEM_WR.
- mem_req, mem_we and addr_sel stay stable while waiting for mem_ack.
- First FETCH after reset: first posedge after rst_n rises moves IDLE→FETCH, so mem_req first asserts on the next cycle. After reset, mem_req is asserted 1 cycle later.

## Test plan
- Reset, then run ADD (0110011), with mem_ack tied to mem_req:
  - Expect states 0,1,2,3,8,1.
  - In EXEC_R: alu_op=10, alu_fn7_en=1.
  - In WB_ALU: reg_we=1. instret becomes 1.
- LW with 3 wait cycles on MEM_RD:
  - mem_req=1 and addr_sel=1 hold for 4 cycles.
  - WB_MEM follows the ack with wb_sel=01.
  - Total 8 cycles. instret increments once.
- BEQ with alu_zero=1, then BNE with alu_zero=1:
  - First: pc_we=1, pc_src=1 in BRANCH.
  - Second: pc_we=0.
  - Both retire, so instret increases by 2.
- ADDI (0010011): alu_fn7_en=0, alu_src_b=10 in EXEC_I. JAL: reg_we=1, wb_sel=10, pc_we=1 in one cycle.
- ECALL (1110011), and separately funct3=010 on a branch opcode:
  - HALT is reached, halt=1, mem_req stays 0 for 100 cycles, instret is unchanged.
- Boundary and reset cases:
  - Force instret to 0xFFFFFFFF, then retire one instruction → instret=0.
  - Assert rst_n=0 mid-MEM_WR wait → mem_req=0 immediately, state=IDLE.
